// File: rtl/heartaware_display_driver.sv
// HeartAware display driver: converts the BPM value to BCD with a sequential
// shift-add-3 engine (one-deep pending buffer in front of it) and time-multiplexes
// the result, plus the UI state code, onto the 8-digit seven-segment display.
module heartaware_display_driver #(
  parameter int unsigned BPM_WIDTH   = 8,
  parameter int unsigned REFRESH_DIV = 25000
) (
  input  logic                 clock_25mhz,
  input  logic                 system_reset_n,
  input  logic [BPM_WIDTH-1:0] bpm_in,
  input  logic                 bpm_valid,
  input  logic [1:0]           ui_state,
  input  logic                 display_en,
  output logic                 busy,
  output logic [6:0]           seg_n,
  output logic                 dp_n,
  output logic [7:0]           an_n
);

  localparam int unsigned      CNT_W      = $clog2(BPM_WIDTH + 1);
  localparam int unsigned      PRE_W      = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(BPM_WIDTH - 1);
  localparam logic [PRE_W-1:0] PRE_LAST   = PRE_W'(REFRESH_DIV - 1);
  localparam logic [6:0]       SEG_BLANK  = 7'h7F;
  localparam logic [6:0]       SEG_DASH   = 7'h3F;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_COMMIT
  } conv_state_e;

  // Active-low segment pattern (G..A) for a decimal digit.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0:    seg_of = 7'h40;
      4'd1:    seg_of = 7'h79;
      4'd2:    seg_of = 7'h24;
      4'd3:    seg_of = 7'h30;
      4'd4:    seg_of = 7'h19;
      4'd5:    seg_of = 7'h12;
      4'd6:    seg_of = 7'h02;
      4'd7:    seg_of = 7'h78;
      4'd8:    seg_of = 7'h00;
      4'd9:    seg_of = 7'h10;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  // Values above 999 do not fit three digits and are shown as dashes.
  function automatic logic is_over(input logic [BPM_WIDTH-1:0] v);
    return 16'(v) > 16'd999;
  endfunction

  // One double-dabble step: add 3 to every nibble >= 5, then shift in the next
  // binary bit. Bit 12 is the carry out of the hundreds nibble.
  function automatic logic [12:0] dabble_step(input logic [11:0] b, input logic bit_in);
    logic [11:0] adj;
    for (int unsigned i = 0; i < 3; i++) begin
      adj[i*4 +: 4] = (b[i*4 +: 4] >= 4'd5) ? b[i*4 +: 4] + 4'd3 : b[i*4 +: 4];
    end
    return {adj, bit_in};
  endfunction

  // Conversion engine state
  conv_state_e          state_q, state_d;
  logic [BPM_WIDTH-1:0] sr_q, sr_d;
  logic [11:0]          bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 over_q, over_d;
  logic                 pend_vld_q, pend_vld_d;
  logic [BPM_WIDTH-1:0] pend_val_q, pend_val_d;
  logic [11:0]          disp_bcd_q, disp_bcd_d;
  logic                 disp_over_q, disp_over_d;

  logic                 load;
  logic [BPM_WIDTH-1:0] load_val;
  logic [12:0]          step;

  // Scan state
  logic [PRE_W-1:0]     pre_q, pre_d;
  logic [2:0]           digit_sel_q, digit_sel_d;
  logic [6:0]           seg_q, seg_d;
  logic [7:0]           an_q, an_d;

  logic [3:0]           ones, tens, hund;

  // Conversion FSM next state, pending buffer and display-register commit.
  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    over_d      = over_q;
    pend_vld_d  = pend_vld_q;
    pend_val_d  = pend_val_q;
    disp_bcd_d  = disp_bcd_q;
    disp_over_d = disp_over_q;
    load        = 1'b0;
    load_val    = bpm_in;
    step        = dabble_step(bcd_q, sr_q[BPM_WIDTH-1]);

    unique case (state_q)
      ST_IDLE: begin
        if (bpm_valid) load = 1'b1;
      end
      ST_SHIFT: begin
        sr_d   = sr_q << 1;
        bcd_d  = step[11:0];
        over_d = over_q | step[12];
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SHIFT) state_d = ST_COMMIT;
        // New values arriving mid-conversion park here; the latest one wins.
        if (bpm_valid) begin
          pend_vld_d = 1'b1;
          pend_val_d = bpm_in;
        end
      end
      ST_COMMIT: begin
        disp_bcd_d  = bcd_q;
        disp_over_d = over_q;
        pend_vld_d  = 1'b0;
        state_d     = ST_IDLE;
        // A strobe on this edge is newer than anything pending, so it takes priority.
        if (bpm_valid) begin
          load = 1'b1;
        end else if (pend_vld_q) begin
          load     = 1'b1;
          load_val = pend_val_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      sr_d    = load_val;
      bcd_d   = '0;
      cnt_d   = '0;
      over_d  = is_over(load_val);
      state_d = ST_SHIFT;
    end
  end

  // Conversion engine registers.
  always_ff @(posedge clock_25mhz or negedge system_reset_n) begin
    if (!system_reset_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      over_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_val_q  <= '0;
      disp_bcd_q  <= '0;
      disp_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      over_q      <= over_d;
      pend_vld_q  <= pend_vld_d;
      pend_val_q  <= pend_val_d;
      disp_bcd_q  <= disp_bcd_d;
      disp_over_q <= disp_over_d;
    end
  end

  // Digit scan prescaler, digit content selection and anode drive.
  always_comb begin
    pre_d       = pre_q + PRE_W'(1);
    digit_sel_d = digit_sel_q;
    if (pre_q == PRE_LAST) begin
      pre_d       = '0;
      digit_sel_d = digit_sel_q + 3'd1;
    end

    ones = disp_bcd_q[3:0];
    tens = disp_bcd_q[7:4];
    hund = disp_bcd_q[11:8];

    seg_d = SEG_BLANK;
    case (digit_sel_q)
      3'd0: seg_d = disp_over_q ? SEG_DASH : seg_of(ones);
      3'd1: seg_d = disp_over_q ? SEG_DASH :
                    ((hund == 4'd0) && (tens == 4'd0)) ? SEG_BLANK : seg_of(tens);
      3'd2: seg_d = disp_over_q ? SEG_DASH :
                    (hund == 4'd0) ? SEG_BLANK : seg_of(hund);
      3'd7: seg_d = seg_of({2'b00, ui_state});
      default: seg_d = SEG_BLANK;
    endcase

    an_d = display_en ? ~(8'h01 << digit_sel_q) : 8'hFF;
  end

  // Scan registers; seg/an are registered so they lag digit_sel by one edge.
  always_ff @(posedge clock_25mhz or negedge system_reset_n) begin
    if (!system_reset_n) begin
      pre_q       <= '0;
      digit_sel_q <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= 8'hFF;
    end else begin
      pre_q       <= pre_d;
      digit_sel_q <= digit_sel_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign seg_n = seg_q;
  assign an_n  = an_q;
  assign dp_n  = 1'b1;

endmodule
